// File: rtl/maxpool_layer_if.sv
// Write/compute/result bundle between a host and maxpool_layer.
interface maxpool_layer_if #(
   parameter int DATA_SIZE = 64
);
   logic                 inmem_wantwrite;
   logic [15:0]          wr_ch;
   logic [15:0]          wr_row;
   logic [15:0]          wr_col;
   logic [DATA_SIZE-1:0] wr_data;
   logic                 compute_start;
   logic                 compute_done;
   logic                 out_valid;
   logic [DATA_SIZE-1:0] out_data;
   logic [15:0]          out_ch;
   logic [15:0]          out_row;
   logic [15:0]          out_col;

   modport master (
      output inmem_wantwrite, wr_ch, wr_row, wr_col, wr_data,
      output compute_start,
      input  compute_done, out_valid, out_data,
      input  out_ch, out_row, out_col
   );

   modport slave (
      input  inmem_wantwrite, wr_ch, wr_row, wr_col, wr_data,
      input  compute_start,
      output compute_done, out_valid, out_data,
      output out_ch, out_row, out_col
   );
endinterface

// File: rtl/maxpool_layer.sv
// Max-pool over a stored NUM_INPUT x INPUT_DIM x INPUT_DIM map, one element per cycle.
// Optional MAXPOOL_RELU_EN clamps negative pooled results to zero.
module maxpool_layer #(
   parameter int DATA_SIZE  = 64,
   parameter int NUM_INPUT  = 16,
   parameter int INPUT_DIM  = 26,
   parameter int KERNEL_DIM = 2
) (
   input logic            clk,
   input logic            reset,
   maxpool_layer_if.slave bus
);
   localparam int OUTPUT_DIM = INPUT_DIM / KERNEL_DIM;
   localparam int DEPTH      = NUM_INPUT * INPUT_DIM * INPUT_DIM;
   localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [31:0] ID32  = 32'(INPUT_DIM);
   localparam logic [31:0] KD32  = 32'(KERNEL_DIM);
   localparam logic [15:0] NI16  = 16'(NUM_INPUT);
   localparam logic [15:0] ID16  = 16'(INPUT_DIM);
   localparam logic [15:0] KM1   = 16'(KERNEL_DIM - 1);
   localparam logic [15:0] OM1   = 16'(OUTPUT_DIM - 1);
   localparam logic [15:0] NM1   = 16'(NUM_INPUT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nx;

   logic signed [DATA_SIZE-1:0] mem [DEPTH];
   logic signed [DATA_SIZE-1:0] rd;
   logic signed [DATA_SIZE-1:0] acc;

   logic [15:0] ch, orow, ocol, kr, kc;
   logic [15:0] res_ch, res_row, res_col;
   logic        win_last;
   logic        draining;
   logic        last_elem;
   logic        last_win;
   logic        wr_ok;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] wr_addr;

   assign rd_addr = AW'((32'(ch) * ID32
                  + 32'(orow) * KD32 + 32'(kr)) * ID32
                  + 32'(ocol) * KD32 + 32'(kc));
   assign wr_addr = AW'((32'(bus.wr_ch) * ID32
                  + 32'(bus.wr_row)) * ID32
                  + 32'(bus.wr_col));
   assign rd = mem[rd_addr];

   assign wr_ok = (state == IDLE) && bus.inmem_wantwrite
               && (bus.wr_ch < NI16) && (bus.wr_row < ID16)
               && (bus.wr_col < ID16);

   assign last_elem = (kr == KM1) && (kc == KM1);
   assign last_win  = last_elem && (ch == NM1)
                   && (orow == OM1) && (ocol == OM1);

   // Storage has no reset: contents survive an aborted pass.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_addr] <= bus.wr_data;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.compute_start) state_nx = RUN;
         RUN:     if (draining) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         ch               <= '0;
         orow             <= '0;
         ocol             <= '0;
         kr               <= '0;
         kc               <= '0;
         acc              <= '0;
         res_ch           <= '0;
         res_row          <= '0;
         res_col          <= '0;
         win_last         <= 1'b0;
         draining         <= 1'b0;
         bus.out_valid    <= 1'b0;
         bus.compute_done <= 1'b0;
         bus.out_data     <= '0;
         bus.out_ch       <= '0;
         bus.out_row      <= '0;
         bus.out_col      <= '0;
      end else begin
         state            <= state_nx;
         bus.out_valid    <= win_last;
         bus.compute_done <= (state == DONE);
         win_last         <= 1'b0;
         // acc already holds the finished window; it reloads this same edge.
         if (win_last) begin
`ifdef MAXPOOL_RELU_EN
            bus.out_data <= acc[DATA_SIZE-1] ? '0 : acc;
`else
            bus.out_data <= acc;
`endif
            bus.out_ch  <= res_ch;
            bus.out_row <= res_row;
            bus.out_col <= res_col;
         end
         if (state == IDLE && bus.compute_start) begin
            ch       <= '0;
            orow     <= '0;
            ocol     <= '0;
            kr       <= '0;
            kc       <= '0;
            draining <= 1'b0;
         end else if (state == RUN && !draining) begin
            if (kr == '0 && kc == '0)
               acc <= rd;
            else if (rd > acc)
               acc <= rd;
            if (kc == KM1) begin
               kc <= '0;
               if (kr == KM1) begin
                  kr <= '0;
                  if (ocol == OM1) begin
                     ocol <= '0;
                     if (orow == OM1) begin
                        orow <= '0;
                        ch   <= ch + 16'd1;
                     end else begin
                        orow <= orow + 16'd1;
                     end
                  end else begin
                     ocol <= ocol + 16'd1;
                  end
               end else begin
                  kr <= kr + 16'd1;
               end
            end else begin
               kc <= kc + 16'd1;
            end
            if (last_elem) begin
               win_last <= 1'b1;
               res_ch   <= ch;
               res_row  <= orow;
               res_col  <= ocol;
            end
            if (last_win)
               draining <= 1'b1;
         end else begin
            draining <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: golden fill, corner windows, aborts, dropped writes.
module tb_maxpool_layer;
   localparam int NI   = 16;
   localparam int ID   = 26;
   localparam int OD   = 13;
   localparam int NWIN = NI * OD * OD;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   logic signed [63:0] shadow [NI][ID][ID];
   logic [63:0]        res_data [NWIN];

   maxpool_layer_if #(.DATA_SIZE(64)) bus ();

   maxpool_layer #(
      .DATA_SIZE(64), .NUM_INPUT(NI),
      .INPUT_DIM(ID), .KERNEL_DIM(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          c, r, k;
      logic [63:0] v0, v1, v2, v3;
      logic [63:0] expect_max;
      logic [63:0] expect_relu;
   } corner_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_win(input int n);
      int c, r, k;
      logic signed [63:0] m;
      c = n / (OD * OD);
      r = (n / OD) % OD;
      k = n % OD;
      m = shadow[c][2*r][2*k];
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            if (shadow[c][2*r+i][2*k+j] > m)
               m = shadow[c][2*r+i][2*k+j];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = '0;
`endif
      return m;
   endfunction

   task automatic wr(input int c, input int r, input int k,
                     input logic [63:0] d);
      bus.inmem_wantwrite = 1'b1;
      bus.wr_ch   = 16'(c);
      bus.wr_row  = 16'(r);
      bus.wr_col  = 16'(k);
      bus.wr_data = d;
      @(posedge clk); #1;
      bus.inmem_wantwrite = 1'b0;
      if (c < NI && r < ID && k < ID)
         shadow[c][r][k] = d;
   endtask

   // Starts a pass and checks every result; disturb injects a write and start mid-run.
   task automatic run_pass(input bit disturb);
      int n, cyc, done_cyc;
      logic [47:0] coord;
      n = 0;
      cyc = 0;
      done_cyc = -1;
      bus.compute_start = 1'b1;
      @(posedge clk); #1;
      bus.compute_start = 1'b0;
      while (cyc < 11000 && done_cyc < 0) begin
         @(posedge clk); #1;
         cyc++;
         if (disturb && cyc == 100) begin
            bus.inmem_wantwrite = 1'b1;
            bus.wr_ch   = 16'd0;
            bus.wr_row  = 16'd0;
            bus.wr_col  = 16'd0;
            bus.wr_data = 64'd99;
            bus.compute_start = 1'b1;
         end else if (disturb && cyc == 101) begin
            bus.inmem_wantwrite = 1'b0;
            bus.compute_start = 1'b0;
         end
         if (bus.out_valid) begin
            if (n < NWIN) begin
               coord = {16'(n / (OD * OD)), 16'((n / OD) % OD), 16'(n % OD)};
               chk("out_data", bus.out_data, exp_win(n));
               chk("out_coord", {16'd0, bus.out_ch, bus.out_row, bus.out_col},
                   {16'd0, coord});
               chk("out_timing", 64'(cyc), 64'(4 * n + 5));
               res_data[n] = bus.out_data;
            end else begin
               chk("extra_out_valid", 64'(n), 64'(NWIN - 1));
            end
            n++;
         end
         if (bus.compute_done) done_cyc = cyc;
      end
      chk("valid_count", 64'(n), 64'(NWIN));
      chk("done_cycle", 64'(done_cyc), 64'd10818);
      @(posedge clk); #1;
      chk("done_single", {63'd0, bus.compute_done}, 64'd0);
      chk("hold_data", bus.out_data, exp_win(NWIN - 1));
      chk("hold_coord", {16'd0, bus.out_ch, bus.out_row, bus.out_col},
          {16'd0, 16'd15, 16'd12, 16'd12});
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
      chk({nm, "_done"}, {63'd0, bus.compute_done}, 64'd0);
      chk({nm, "_data"}, bus.out_data, 64'd0);
      chk({nm, "_coord"}, {16'd0, bus.out_ch, bus.out_row, bus.out_col}, 64'd0);
   endtask

   corner_t tbl [6];

   initial begin
      int bad;
      checks = 0;
      errors = 0;
      tbl[0] = '{0, 0, 0, -64'sd5, -64'sd3, -64'sd9, -64'sd4,
                 -64'sd3, 64'd0};
      tbl[1] = '{0, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
      tbl[2] = '{0, 0, 2, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
      tbl[3] = '{0, 1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'd0};
      tbl[4] = '{0, 1, 1, 64'd10, 64'd20, 64'd20, 64'd5, 64'd20, 64'd20};
      tbl[5] = '{7, 12, 12, -64'sd1, 64'd0, -64'sd7, -64'sd2, 64'd0, 64'd0};

      reset = 1'b1;
      bus.inmem_wantwrite = 1'b0;
      bus.wr_ch = '0;
      bus.wr_row = '0;
      bus.wr_col = '0;
      bus.wr_data = '0;
      bus.compute_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b0;

      for (int c = 0; c < NI; c++)
         for (int i = 0; i < ID; i++)
            for (int j = 0; j < ID; j++)
               wr(c, i, j, 64'(c * 1000 + i * 26 + j));
      // Out-of-range coordinates must not alias onto real cells.
      wr(0, 0, 26, 64'd12345678);
      wr(16, 0, 0, 64'd12345678);
      wr(0, 26, 0, 64'd12345678);

      run_pass(1'b1);
      chk("first_golden", res_data[0], 64'd27);
      chk("last_golden", res_data[NWIN-1], 64'd15675);

      bus.compute_start = 1'b1;
      @(posedge clk); #1;
      bus.compute_start = 1'b0;
      repeat (499) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk_reset_outputs("abort");
      bad = 0;
      for (int t = 501; t < 600; t++) begin
         @(posedge clk); #1;
         if (t == 550) reset = 1'b0;
         if (bus.out_valid || bus.compute_done) bad++;
      end
      chk("abort_quiet", 64'(bad), 64'd0);
      run_pass(1'b0);

      foreach (tbl[e]) begin
         wr(tbl[e].c, 2*tbl[e].r,   2*tbl[e].k,   tbl[e].v0);
         wr(tbl[e].c, 2*tbl[e].r,   2*tbl[e].k+1, tbl[e].v1);
         wr(tbl[e].c, 2*tbl[e].r+1, 2*tbl[e].k,   tbl[e].v2);
         wr(tbl[e].c, 2*tbl[e].r+1, 2*tbl[e].k+1, tbl[e].v3);
      end
      run_pass(1'b0);
      for (int e = 0; e < 6; e++) begin
`ifdef MAXPOOL_RELU_EN
         chk($sformatf("corner%0d", e),
             res_data[tbl[e].c*OD*OD + tbl[e].r*OD + tbl[e].k],
             tbl[e].expect_relu);
`else
         chk($sformatf("corner%0d", e),
             res_data[tbl[e].c*OD*OD + tbl[e].r*OD + tbl[e].k],
             tbl[e].expect_max);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/maxpool_layer.md
MAXPOOL_LAYER -- requirements
Module: maxpool_layer

Interface
REQ-001 Parameter DATA_SIZE, default 64: width of one feature-map word.
REQ-002 Parameter NUM_INPUT, default 16: number of channels.
REQ-003 Parameter INPUT_DIM, default 26: input rows = input columns.
REQ-004 Parameter KERNEL_DIM, default 2: pooling window edge and stride; OUTPUT_DIM = INPUT_DIM / KERNEL_DIM (floor).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 inmem_wantwrite  in  1  write strobe for input memory.
REQ-008 wr_ch, wr_row, wr_col  in  16 each  write coordinates (channel, row, column).
REQ-009 wr_data  in  DATA_SIZE  signed two's-complement word to store.
REQ-010 compute_start  in  1  single-cycle request to pool the stored map.
REQ-011 compute_done  out  1  single-cycle pulse: pass complete.
REQ-012 out_valid  out  1  single-cycle pulse per pooled result.
REQ-013 out_data  out  DATA_SIZE  pooled value, valid when out_valid=1.
REQ-014 out_ch, out_row, out_col  out  16 each  result coordinates, valid when out_valid=1.

Function
REQ-015 Internal storage: NUM_INPUT*INPUT_DIM*INPUT_DIM words, asynchronous read, synchronous write.
REQ-016 States: IDLE, RUN, DONE; IDLE -> RUN on compute_start; RUN -> DONE after last window; DONE -> IDLE after one cycle.
REQ-017 In IDLE, inmem_wantwrite=1 with all coordinates in range writes wr_data at (wr_ch,wr_row,wr_col) that cycle; out-of-range coordinates drop the write.
REQ-018 Writes while in RUN or DONE are dropped; memory is unchanged.
REQ-019 compute_start outside IDLE is ignored.
REQ-020 Window order: channel outermost, then output row, then output column innermost; window (c,r,k) covers rows r*KERNEL_DIM.., columns k*KERNEL_DIM...
REQ-021 Each window takes exactly KERNEL_DIM^2 cycles, one element read per cycle, row-major within window; windows back-to-back with no gap.
REQ-022 Accumulator: first element of window loads; later elements keep the signed maximum (ties keep the held value).
REQ-023 compute_start accepted at edge T: window w reads at T+1+K²w .. T+K²(w+1); out_valid at T+1+K²(w+1) with coordinates of window w.
REQ-024 compute_done pulses the cycle after the final out_valid (default sizes: out_valid last at T+10817, compute_done at T+10818); out_valid count = NUM_INPUT*OUTPUT_DIM².
REQ-025 Odd INPUT_DIM: trailing row and column are never read.
REQ-026 out_data and coordinates hold their last value when out_valid=0.

Reset
REQ-027 reset=1 forces IDLE immediately, independent of clk; compute_done, out_valid, out_data, out_ch, out_row, out_col, accumulator and counters go to 0.
REQ-028 Reset mid-RUN aborts the pass: no further out_valid, no compute_done; memory contents are retained, not cleared.
REQ-029 After reset deassertion, the block accepts writes and compute_start on the next rising edge.

Configuration
REQ-030 Macro MAXPOOL_RELU_EN defined: out_data = 0 whenever the pooled maximum is negative, else the maximum.
REQ-031 MAXPOOL_RELU_EN undefined: out_data is the signed maximum unmodified; timing is identical in both builds.

Verification
REQ-032 Fill channel c, row i, column j with c*1000+i*26+j; start -> 2704 out_valid pulses, first (0,0,0)=27, last (15,12,12)=15675, compute_done at T+10818.
REQ-033 Window (0,0,0) = {-5,-3,-9,-4}: without macro out_data=-3; with MAXPOOL_RELU_EN out_data=0.
REQ-034 Window of four equal values 0x7FFF_FFFF_FFFF_FFFF -> out_data 0x7FFF_FFFF_FFFF_FFFF; mixed with 0x8000_0000_0000_0000 -> still the positive value.
REQ-035 Assert reset at T+500 during RUN -> out_valid and compute_done stay 0 and state is IDLE; restart at T+600 -> full 2704-result pass with memory data unchanged.
REQ-036 Write (0,0,0)=99 and compute_start mid-RUN -> memory unchanged and start ignored; results identical to golden model; write with wr_col=26 in IDLE -> dropped.
